// File: rtl/wave_fb_writer_if.sv
// Purpose : bundles the pixel stream from the wave filter and the frame-buffer write port.
// Latency : none, wires only.
// Backpr. : the pixel side has no ready; the write side uses fb_valid_out/fb_ready_in.
// Ports   : pixel_in/hcount_in/vcount_in/data_valid_in (filter -> writer),
//           fb_addr_out/fb_data_out/fb_valid_out (writer -> frame buffer), fb_ready_in (frame buffer -> writer).
// Modports: slave = writer view, master = driver/frame-buffer view.
interface wave_fb_writer_if #(
    parameter int ADDR_W = 17
);
    logic [6:0]        pixel_in;
    logic [10:0]       hcount_in;
    logic [9:0]        vcount_in;
    logic              data_valid_in;
    logic [ADDR_W-1:0] fb_addr_out;
    logic [6:0]        fb_data_out;
    logic              fb_valid_out;
    logic              fb_ready_in;

    modport slave (
        input  pixel_in, hcount_in, vcount_in, data_valid_in, fb_ready_in,
        output fb_addr_out, fb_data_out, fb_valid_out
    );

    modport master (
        output pixel_in, hcount_in, vcount_in, data_valid_in, fb_ready_in,
        input  fb_addr_out, fb_data_out, fb_valid_out
    );
endinterface

// File: rtl/wave_fb_writer.sv
// Purpose : clips filter pixels to the WIDTH x HEIGHT frame, forms vcount*WIDTH+hcount and queues writes.
// Latency : 2 cycles from data_valid_in to fb_valid_out when the queue is empty.
// Backpr. : none upstream; a full queue without a pop on the same edge drops the new pixel.
// Ports   : clk_in, rst_in (sync, active-low), bus (wave_fb_writer_if.slave), frame_done_out,
//           drop_count_out only when WAVE_FB_DROP_COUNT_EN is defined (saturating full-queue drop count).
module wave_fb_writer #(
    parameter int WIDTH      = 320,
    parameter int HEIGHT     = 320,
    parameter int ADDR_W     = 17,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                   clk_in,
    input  logic                   rst_in,
    wave_fb_writer_if.slave        bus,
`ifdef WAVE_FB_DROP_COUNT_EN
    output logic [15:0]            drop_count_out,
`endif
    output logic                   frame_done_out
);
    localparam int                PTR_W    = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam logic [10:0]       W_LIM    = 11'(WIDTH);
    localparam logic [9:0]        H_LIM    = 10'(HEIGHT);
    localparam logic [10:0]       W_LAST   = 11'(WIDTH - 1);
    localparam logic [9:0]        H_LAST   = 10'(HEIGHT - 1);
    localparam logic [ADDR_W-1:0] W_MUL    = ADDR_W'(WIDTH);
    localparam logic [PTR_W:0]    CNT_FULL = (PTR_W + 1)'(FIFO_DEPTH);
    localparam logic [PTR_W:0]    CNT_ONE  = (PTR_W + 1)'(1);
    localparam logic [PTR_W-1:0]  PTR_ONE  = PTR_W'(1);

    // S1 registers. The product is kept at ADDR_W bits: the address is taken
    // modulo 2^ADDR_W anyway, so truncating early loses nothing.
    logic              r_s1_vld;
    logic              r_s1_inr;
    logic              r_s1_last;
    logic [6:0]        r_s1_pix;
    logic [10:0]       r_s1_h;
    logic [ADDR_W-1:0] r_s1_prod;

    always_ff @(posedge clk_in) begin
        if (!rst_in) begin
            r_s1_vld  <= 1'b0;
            r_s1_inr  <= 1'b0;
            r_s1_last <= 1'b0;
            r_s1_pix  <= '0;
            r_s1_h    <= '0;
            r_s1_prod <= '0;
        end else begin
            r_s1_vld <= bus.data_valid_in;
            if (bus.data_valid_in) begin
                r_s1_pix  <= bus.pixel_in;
                r_s1_h    <= bus.hcount_in;
                r_s1_prod <= ADDR_W'(bus.vcount_in) * W_MUL;
                r_s1_inr  <= (bus.hcount_in < W_LIM) && (bus.vcount_in < H_LIM);
                r_s1_last <= (bus.hcount_in == W_LAST) && (bus.vcount_in == H_LAST);
            end
        end
    end

    // S2: push into the write queue.
    logic [ADDR_W-1:0] r_mem_addr [FIFO_DEPTH];
    logic [6:0]        r_mem_pix  [FIFO_DEPTH];
    logic [PTR_W-1:0]  r_wr_ptr;
    logic [PTR_W-1:0]  r_rd_ptr;
    logic [PTR_W:0]    r_count;
    logic              r_frame_done;

    logic              w_empty;
    logic              w_full;
    logic              w_pop;
    logic              w_push_req;
    logic              w_push;
    logic [ADDR_W-1:0] w_addr;

    assign w_empty    = (r_count == '0);
    assign w_full     = (r_count == CNT_FULL);
    assign w_pop      = !w_empty && bus.fb_ready_in;
    assign w_push_req = r_s1_vld && r_s1_inr;
    // A pop on the same edge frees the slot, so a full queue still accepts.
    assign w_push     = w_push_req && (!w_full || w_pop);
    assign w_addr     = r_s1_prod + ADDR_W'(r_s1_h);

    always_ff @(posedge clk_in) begin
        if (!rst_in) begin
            // Entries are cleared too so the head reads as zero out of reset.
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                r_mem_addr[i] <= '0;
                r_mem_pix[i]  <= '0;
            end
            r_wr_ptr     <= '0;
            r_rd_ptr     <= '0;
            r_count      <= '0;
            r_frame_done <= 1'b0;
        end else begin
            if (w_push) begin
                r_mem_addr[r_wr_ptr] <= w_addr;
                r_mem_pix[r_wr_ptr]  <= r_s1_pix;
                r_wr_ptr             <= r_wr_ptr + PTR_ONE;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_ONE;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CNT_ONE;
                2'b01:   r_count <= r_count - CNT_ONE;
                default: r_count <= r_count;
            endcase
            // Last pixel is in range by construction; fires even if the push was dropped.
            r_frame_done <= r_s1_vld && r_s1_inr && r_s1_last;
        end
    end

    assign bus.fb_valid_out = !w_empty;
    assign bus.fb_addr_out  = r_mem_addr[r_rd_ptr];
    assign bus.fb_data_out  = r_mem_pix[r_rd_ptr];
    assign frame_done_out   = r_frame_done;

`ifdef WAVE_FB_DROP_COUNT_EN
    logic        w_drop;
    logic [15:0] r_drop_cnt;

    // Only queue-full drops count; clipped coordinates never reach w_push_req.
    assign w_drop = w_push_req && w_full && !w_pop;

    always_ff @(posedge clk_in) begin
        if (!rst_in) begin
            r_drop_cnt <= '0;
        end else if (w_drop && (r_drop_cnt != 16'hFFFF)) begin
            r_drop_cnt <= r_drop_cnt + 16'd1;
        end
    end

    assign drop_count_out = r_drop_cnt;
`endif
endmodule

// File: tb/tb_wave_fb_writer.sv
// Purpose : directed, table-driven bench for wave_fb_writer.
// Latency : n/a.
// Backpr. : drives fb_ready_in directly.
module tb_wave_fb_writer;
    logic clk = 1'b0;
    logic rst_n;
    logic frame_done;
`ifdef WAVE_FB_DROP_COUNT_EN
    logic [15:0] drops;
`endif

    wave_fb_writer_if #(.ADDR_W(17)) bus ();

    wave_fb_writer #(
        .WIDTH(320), .HEIGHT(320), .ADDR_W(17), .FIFO_DEPTH(4)
    ) dut (
        .clk_in         (clk),
        .rst_in         (rst_n),
        .bus            (bus),
`ifdef WAVE_FB_DROP_COUNT_EN
        .drop_count_out (drops),
`endif
        .frame_done_out (frame_done)
    );

    always #5 clk = ~clk;

    typedef struct {
        int h;
        int v;
        int px;
        bit push;
        int addr;
        bit done;
    } vec_t;

    vec_t tbl[10];
    int   total = 0;
    int   bad   = 0;
    int   got[$];
    int   first_c;
    int   last_c;
    int   wr_cnt;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input bit v, input int h, input int vc, input int px);
        bus.data_valid_in = v;
        bus.hcount_in     = 11'(h);
        bus.vcount_in     = 10'(vc);
        bus.pixel_in      = 7'(px);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        tbl[0] = '{5,    2,    'h2A, 1'b1, 645,    1'b0};
        tbl[1] = '{320,  0,    'h11, 1'b0, 0,      1'b0};
        tbl[2] = '{0,    320,  'h12, 1'b0, 0,      1'b0};
        tbl[3] = '{1023, 1023, 'h13, 1'b0, 0,      1'b0};
        tbl[4] = '{319,  319,  'h55, 1'b1, 102399, 1'b1};
        tbl[5] = '{0,    0,    'h01, 1'b1, 0,      1'b0};
        tbl[6] = '{319,  0,    'h7F, 1'b1, 319,    1'b0};
        tbl[7] = '{0,    319,  'h33, 1'b1, 102080, 1'b0};
        tbl[8] = '{2047, 1023, 'h44, 1'b0, 0,      1'b0};
        tbl[9] = '{319,  320,  'h66, 1'b0, 0,      1'b0};

        // Reset state
        rst_n = 1'b0;
        drive(0, 0, 0, 0);
        bus.fb_ready_in = 1'b0;
        step();
        step();
        chk("rst_valid", 32'(bus.fb_valid_out), 0);
        chk("rst_addr",  32'(bus.fb_addr_out),  0);
        chk("rst_data",  32'(bus.fb_data_out),  0);
        chk("rst_done",  32'(frame_done),       0);
`ifdef WAVE_FB_DROP_COUNT_EN
        chk("rst_drops", 32'(drops), 0);
`endif
        rst_n = 1'b1;
        step();

        // Single pixels: latency, clipping, address math, frame done
        bus.fb_ready_in = 1'b1;
        for (int i = 0; i < 10; i++) begin
            drive(1, tbl[i].h, tbl[i].v, tbl[i].px);
            step();
            drive(0, 0, 0, 0);
            step();
            chk($sformatf("vec%0d_valid", i), 32'(bus.fb_valid_out), 32'(tbl[i].push));
            chk($sformatf("vec%0d_done", i),  32'(frame_done),       32'(tbl[i].done));
            if (tbl[i].push) begin
                chk($sformatf("vec%0d_addr", i), 32'(bus.fb_addr_out), 32'(tbl[i].addr));
                chk($sformatf("vec%0d_data", i), 32'(bus.fb_data_out), 32'(tbl[i].px));
            end
            step();
            chk($sformatf("vec%0d_valid_after", i), 32'(bus.fb_valid_out), 0);
            chk($sformatf("vec%0d_done_after", i),  32'(frame_done),       0);
        end
`ifdef WAVE_FB_DROP_COUNT_EN
        chk("clip_drops", 32'(drops), 0);
`endif

        // Back-pressure: 6 pixels into a 4-deep queue
        bus.fb_ready_in = 1'b0;
        for (int i = 0; i < 6; i++) begin
            drive(1, i, 0, 'h10 + i);
            step();
        end
        drive(0, 0, 0, 0);
        step();
        step();
        chk("bp_valid", 32'(bus.fb_valid_out), 1);
        chk("bp_head_addr", 32'(bus.fb_addr_out), 0);
        chk("bp_head_data", 32'(bus.fb_data_out), 'h10);
        step();
        step();
        chk("bp_head_stable", 32'(bus.fb_addr_out), 0);
`ifdef WAVE_FB_DROP_COUNT_EN
        chk("bp_drops", 32'(drops), 2);
`endif
        bus.fb_ready_in = 1'b1;
        got.delete();
        for (int c = 0; c < 10; c++) begin
            if (bus.fb_valid_out) got.push_back(int'(bus.fb_addr_out));
            step();
        end
        chk("bp_write_count", 32'(got.size()), 4);
        for (int k = 0; k < got.size() && k < 4; k++)
            chk($sformatf("bp_write%0d", k), 32'(got[k]), 32'(k));

        // Push and pop on the same edge while full
        bus.fb_ready_in = 1'b0;
        for (int i = 0; i < 4; i++) begin
            drive(1, 10 + i, 0, i);
            step();
        end
        drive(0, 0, 0, 0);
        step();
        step();
        chk("pp_full_head", 32'(bus.fb_addr_out), 10);
        got.delete();
        first_c = -1;
        last_c  = -1;
        for (int c = 0; c < 20; c++) begin
            if (c < 8) drive(1, 14 + c, 0, c);
            else       drive(0, 0, 0, 0);
            if (c >= 1) bus.fb_ready_in = 1'b1;
            if (bus.fb_valid_out && bus.fb_ready_in) begin
                got.push_back(int'(bus.fb_addr_out));
                if (first_c < 0) first_c = c;
                last_c = c;
            end
            step();
        end
        chk("pp_write_count", 32'(got.size()), 12);
        for (int k = 0; k < got.size() && k < 12; k++)
            chk($sformatf("pp_write%0d", k), 32'(got[k]), 32'(10 + k));
        chk("pp_one_per_cycle", 32'(last_c - first_c), 11);
`ifdef WAVE_FB_DROP_COUNT_EN
        chk("pp_drops", 32'(drops), 2);
`endif

        // Reset with queued and in-flight pixels
        bus.fb_ready_in = 1'b0;
        for (int i = 0; i < 3; i++) begin
            drive(1, 30 + i, 0, i);
            step();
        end
        drive(0, 0, 0, 0);
        step();
        step();
        chk("mr_valid_before", 32'(bus.fb_valid_out), 1);
        drive(1, 40, 0, 5);
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        drive(0, 0, 0, 0);
        chk("mr_valid_after", 32'(bus.fb_valid_out), 0);
        chk("mr_addr_after",  32'(bus.fb_addr_out),  0);
`ifdef WAVE_FB_DROP_COUNT_EN
        chk("mr_drops", 32'(drops), 0);
`endif
        bus.fb_ready_in = 1'b1;
        wr_cnt = 0;
        for (int c = 0; c < 8; c++) begin
            if (bus.fb_valid_out) wr_cnt++;
            step();
        end
        chk("mr_no_writes", 32'(wr_cnt), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
